datapath_seq_ctrl: RTL and testbench
====================================

Name: datapath_seq_ctrl

Overview:
- Control-step sequencer for the RA/RB/RZ single-bus add datapath.
- Drives the register-enable and bus-source select lines to compute RB = Imm + N*A, where Imm is the RA immediate and A is the adder's fixed operand.
- Sits beside the datapath. Accepts start/count from the test harness or a higher-level control unit, and returns busy/done.
- Replaces hand-toggled control signals in benches.

Parameters:
- CNT_W, 4, width of the iteration count; N ranges 0..2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request pulse or level; sampled only in IDLE.
- count  in  CNT_W  iteration count N; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- RAin  out  1  load RA from the immediate.
- RBin  out  1  load RB from the bus.
- RZin  out  1  load RZ from the adder.
- RAout  out  1  RA drives the bus.
- RBout  out  1  RB drives the bus.
- RZout  out  1  RZ drives the bus.
- step  out  3  current state encoding, for debug and bench visibility.

Behaviour:
- Clock and reset: single clock clk. Reset clear is synchronous and active-high. clear has priority over every other input.
- Reset state: state=IDLE, remaining counter=0. All outputs are 0, including busy, done and all six control lines.
- Output timing: outputs are a pure decode of the state register. Each control line is asserted for exactly the full cycle of its state. No outputs depend combinationally on start or count.
- Bus source invariant: at most one of RAout/RBout/RZout is high in any cycle. This holds in every state, including across reset.
- States and encoding on step: IDLE=0, LOAD_A=1, MOVE_AB=2, ADD=3, WRBACK=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge with all outputs 0.
- IDLE:
  - No controls asserted.
  - If start=1: latch remaining<=count.
  - If count==0, go to DONE; otherwise go to LOAD_A.
- LOAD_A: RAin=1 (RA <= immediate). Go to MOVE_AB.
- MOVE_AB: RAout=1, RBin=1 (RB <= RA). Go to ADD.
- ADD: RBout=1, RZin=1 (RZ <= A + RB). Go to WRBACK.
- WRBACK:
  - RZout=1, RBin=1 (RB <= RZ).
  - remaining <= remaining-1.
  - If remaining==1 (before the decrement), go to DONE; else go to ADD.
- DONE: done=1, busy=1. Go to IDLE unconditionally.
- Latency: with the start edge at cycle 0, done is high in cycle 2N+3. For N=0, done is high in cycle 1.
- Back-to-back runs: start held high re-triggers in the IDLE cycle after DONE. There is a minimum of one idle cycle between runs.
- start while busy: ignored. It is not queued, and remaining is unaffected.
- count changes while busy: ignored, because the value was latched at acceptance.
- Arithmetic: the adder's carry-out is ignored, so the result wraps modulo 2^32. The controller does no arithmetic except the CNT_W-bit decrement. remaining never underflows, because the 1→DONE exit happens before 0 is reached.
- clear mid-operation: on the next edge, state goes to IDLE and all control lines drop to 0. Datapath register contents are undefined to the controller; the datapath's own clear governs them. No done pulse is produced for an aborted run.
- clear and start in the same cycle: clear wins. start is not accepted.

Test Plan:
1. Single iteration: A=5, Imm=3, count=1, start pulse at cycle 0.
   - Required: LOAD_A@1, MOVE_AB@2, ADD@3, WRBACK@4, done@5.
   - RB=8 after done; busy high for cycles 1–5.
2. Three iterations: A=2, Imm=10, count=3.
   - Required: done@9 and RB=16.
   - Trace the RZ sequence 12, 14, 16, with RBin asserted exactly 4 times.
3. Zero count: count=0, start pulse.
   - Required: done@1 and busy@1 only.
   - No control line ever asserted; RB unchanged.
4. Wrap and ignore: A=0xFFFFFFFF, Imm=2, count=2. Pulse start again at cycle 3 with count=9.
   - Required: RB=0x00000000 at done@7.
   - The second start is ignored; the run takes exactly 2 iterations.
5. Abort: count=5; assert clear for one cycle while in ADD.
   - Required: next cycle step=0, all outputs 0, and no done pulse.
   - A new start then runs normally to done at 2N+3.
6. Continuous checker across all tests:
   - RAout+RBout+RZout ≤ 1 every cycle.
   - done is never high for 2 consecutive cycles.
   - busy == (step != 0).

Source files
------------

// File: rtl/datapath_seq_ctrl_if.sv
// Handshake and control-line bundle between the add-datapath sequencer and its host.
interface datapath_seq_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             RAin;
  logic             RBin;
  logic             RZin;
  logic             RAout;
  logic             RBout;
  logic             RZout;
  logic [2:0]       step;

  // Host side: issues start/count and observes status and control lines.
  modport master (
    output start, count,
    input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout, step
  );

  // Sequencer side.
  modport slave (
    input  start, count,
    output busy, done, RAin, RBin, RZin, RAout, RBout, RZout, step
  );
endinterface

// File: rtl/datapath_seq_ctrl.sv
// Control-step sequencer computing RB = Imm + N*A on the RA/RB/RZ single-bus datapath.
module datapath_seq_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  datapath_seq_ctrl_if.slave   ctl
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_MOVE_AB = 3'd2,
    S_ADD     = 3'd3,
    S_WRBACK  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic ra_in;
    logic rb_in;
    logic rz_in;
    logic ra_out;
    logic rb_out;
    logic rz_out;
  } ctl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  ctl_t             out_q, out_d;

  // State, remaining count and registered control lines; clear dominates.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  // Next-state and iteration-count update.
  always_comb begin
    state_d = S_IDLE;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          rem_d   = ctl.count;
          state_d = (ctl.count == '0) ? S_DONE : S_LOAD_A;
        end
      end
      S_LOAD_A:  state_d = S_MOVE_AB;
      S_MOVE_AB: state_d = S_ADD;
      S_ADD:     state_d = S_WRBACK;
      S_WRBACK: begin
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_ADD;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Decode of the upcoming state, registered so each line is glitch-free for its whole state cycle.
  always_comb begin
    out_d = '0;
    case (state_d)
      S_LOAD_A: begin
        out_d.busy  = 1'b1;
        out_d.ra_in = 1'b1;
      end
      S_MOVE_AB: begin
        out_d.busy   = 1'b1;
        out_d.ra_out = 1'b1;
        out_d.rb_in  = 1'b1;
      end
      S_ADD: begin
        out_d.busy   = 1'b1;
        out_d.rb_out = 1'b1;
        out_d.rz_in  = 1'b1;
      end
      S_WRBACK: begin
        out_d.busy   = 1'b1;
        out_d.rz_out = 1'b1;
        out_d.rb_in  = 1'b1;
      end
      S_DONE: begin
        out_d.busy = 1'b1;
        out_d.done = 1'b1;
      end
      default: out_d = '0;
    endcase
  end

  assign ctl.busy  = out_q.busy;
  assign ctl.done  = out_q.done;
  assign ctl.RAin  = out_q.ra_in;
  assign ctl.RBin  = out_q.rb_in;
  assign ctl.RZin  = out_q.rz_in;
  assign ctl.RAout = out_q.ra_out;
  assign ctl.RBout = out_q.rb_out;
  assign ctl.RZout = out_q.rz_out;
  assign ctl.step  = state_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Bench for datapath_seq_ctrl: drives runs against a behavioural datapath and an arithmetic schedule model.
module tb_datapath_seq_ctrl;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic clear;
  logic checking = 1'b0;
  logic prev_done = 1'b0;
  int   total = 0;
  int   bad = 0;

  datapath_seq_ctrl_if #(.CNT_W(CNT_W)) ctl ();

  datapath_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clear (clear),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  // Behavioural single-bus datapath reacting to the sequencer's control lines.
  logic [31:0] a_val = '0;
  logic [31:0] imm_val = '0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic [31:0] rz = '0;
  logic [31:0] bus;

  always_comb bus = ctl.RAout ? ra : ctl.RBout ? rb : ctl.RZout ? rz : 32'h0;

  always @(posedge clk) begin
    if (ctl.RAin) ra <= imm_val;
    if (ctl.RBin) rb <= bus;
    if (ctl.RZin) rz <= a_val + bus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {ctl.busy, ctl.done, ctl.RAin, ctl.RBin, ctl.RZin, ctl.RAout, ctl.RBout, ctl.RZout};
  endfunction

  // Control-line table per state: {busy,done,RAin,RBin,RZin,RAout,RBout,RZout}.
  function automatic logic [7:0] exp_outs(input int s);
    case (s)
      1:       return 8'b1010_0000;
      2:       return 8'b1001_0100;
      3:       return 8'b1000_1010;
      4:       return 8'b1001_0001;
      5:       return 8'b1100_0000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Expected step in cycle k after the start edge for an N-iteration run.
  function automatic int exp_step(input int k, input int n);
    if (n == 0) return (k == 1) ? 5 : 0;
    if (k == 1) return 1;
    if (k == 2) return 2;
    if (k >= 3 && k <= 2 * n + 2) return (k % 2 == 1) ? 3 : 4;
    if (k == 2 * n + 3) return 5;
    return 0;
  endfunction

  // Invariants checked every cycle once out of initial reset.
  always @(negedge clk) begin
    if (checking) begin
      check("bus_src_le1", 32'(ctl.RAout + ctl.RBout + ctl.RZout <= 2'd1), 32'd1);
      check("done_twice", 32'(prev_done && ctl.done), 32'd0);
      check("busy_vs_step", 32'(ctl.busy), 32'(ctl.step != 3'd0));
      prev_done = ctl.done;
    end
  end

  // One run from an IDLE negedge; optional late start (restart_at) and clear during the run (abort_at).
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] imm, input int n,
                     input int restart_at, input int abort_at);
    int          rbin_cnt;
    int          iter;
    int          last;
    int          s;
    logic [31:0] rb_before;
    rbin_cnt  = 0;
    iter      = 0;
    a_val     = a;
    imm_val   = imm;
    rb_before = rb;
    ctl.start = 1'b1;
    ctl.count = CNT_W'(n);
    @(posedge clk);
    last = (n == 0) ? 2 : 2 * n + 4;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ctl.start = 1'b0;
        ctl.count = CNT_W'($urandom);
      end
      if (abort_at > 0 && k > abort_at) begin
        check({tag, "_abort_step"}, 32'(ctl.step), 32'd0);
        check({tag, "_abort_outs"}, 32'(outs()), 32'd0);
        clear = 1'b0;
        if (k == abort_at + 3) break;
        continue;
      end
      s = exp_step(k, n);
      check({tag, "_step"}, 32'(ctl.step), 32'(s));
      check({tag, "_ctl"}, 32'(outs()), 32'(exp_outs(s)));
      if (ctl.RBin) rbin_cnt++;
      if (s == 4) begin
        iter++;
        check({tag, "_rz"}, rz, imm + 32'(iter) * a);
      end
      if (s == 5) check({tag, "_rb"}, rb, (n == 0) ? rb_before : imm + 32'(n) * a);
      if (restart_at == k) begin
        ctl.start = 1'b1;
        ctl.count = CNT_W'(9);
      end
      if (restart_at > 0 && k == restart_at + 1) ctl.start = 1'b0;
      if (abort_at == k) clear = 1'b1;
    end
    if (abort_at == 0) check({tag, "_rbin_cnt"}, 32'(rbin_cnt), (n == 0) ? 32'd0 : 32'(n + 1));
  endtask

  initial begin
    int exp_b2b [7];
    exp_b2b = '{1, 2, 3, 4, 5, 0, 1};
    clear     = 1'b1;
    ctl.start = 1'b1;
    ctl.count = CNT_W'(3);
    repeat (2) @(negedge clk);
    check("rst_step", 32'(ctl.step), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    ctl.start = 1'b0;
    clear     = 1'b0;
    checking  = 1'b1;
    @(negedge clk);
    check("idle_step", 32'(ctl.step), 32'd0);

    run("single", 32'd5, 32'd3, 1, 0, 0);
    run("three", 32'd2, 32'd10, 3, 0, 0);
    run("zero", 32'd7, 32'd1, 0, 0, 0);
    run("wrap", 32'hFFFF_FFFF, 32'd2, 2, 3, 0);
    run("abort", 32'd3, 32'd4, 5, 0, 3);
    run("after_abort", 32'd3, 32'd4, 5, 0, 0);

    // start held high re-triggers one idle cycle after DONE
    a_val     = 32'd1;
    imm_val   = 32'd1;
    ctl.start = 1'b1;
    ctl.count = CNT_W'(1);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("b2b_step", 32'(ctl.step), 32'(exp_b2b[k]));
    end
    ctl.start = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_idle", 32'(ctl.step), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run("rand", $urandom, $urandom, int'($urandom_range(0, 15)), 0, 0);
    end

    // clear and start in the same cycle: start must not be accepted
    ctl.start = 1'b1;
    ctl.count = CNT_W'(4);
    clear     = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    clear     = 1'b0;
    check("clr_start_step", 32'(ctl.step), 32'd0);
    check("clr_start_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    check("clr_start_idle", 32'(ctl.step), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
